// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score scan controller.
package score_pkg;

    localparam int unsigned N_CELLS   = 16;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned VAL_W     = 16;
    localparam int unsigned SCORE_W   = 20;  // holds N_CELLS * 2^14 without overflow
    localparam int unsigned WIN_STATE = 11;  // state code of the 2048 tile
    localparam int unsigned ADDR_W    = $clog2(N_CELLS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/score_accum.sv
// Score accumulator: valid pipe aligned to the 1-cycle decoder latency, a SCORE_W
// adder with synchronous clear, and a running max of the scanned state codes.
module score_accum
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               dec_en,
    input  logic [VAL_W-1:0]   dec_value,
    input  logic               track_en,
    input  logic [STATE_W-1:0] track_state,
    output logic [SCORE_W-1:0] acc,
    output logic [STATE_W-1:0] max_tracked
);

    logic               valid_q;
    logic [SCORE_W-1:0] acc_q, acc_d;
    logic [STATE_W-1:0] max_q, max_d;

    // Next-state for accumulator and max tracker; clear wins over update.
    always_comb begin
        acc_d = acc_q;
        max_d = max_q;
        if (clr) begin
            acc_d = '0;
            max_d = '0;
        end else begin
            if (valid_q) begin
                acc_d = acc_q + SCORE_W'(dec_value);
            end
            if (track_en && (track_state > max_q)) begin
                max_d = track_state;
            end
        end
    end

    // State registers; valid_q marks the cycle the decoder result lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            max_q   <= '0;
        end else begin
            valid_q <= dec_en;
            acc_q   <= acc_d;
            max_q   <= max_d;
        end
    end

    assign acc         = acc_q;
    assign max_tracked = max_q;

endmodule

// File: rtl/score_scan_controller.sv
// Scans every board cell through the external tile-value decoder and reports the
// score, highest tile state and win flag with a one-cycle done pulse.
// Optional SCORE_HIGH_SCORE_EN adds best_score / new_best high-score tracking.
module score_scan_controller
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  cell_addr,
    input  logic [STATE_W-1:0] cell_state,
    output logic               dec_en,
    output logic [STATE_W-1:0] dec_state,
    input  logic [VAL_W-1:0]   dec_value,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic [STATE_W-1:0] max_state,
    output logic               win
`ifdef SCORE_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best
`endif
);

    localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(N_CELLS - 1);
    localparam logic [STATE_W-1:0] WinCode  = STATE_W'(WIN_STATE);

    scan_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [STATE_W-1:0] max_q, max_d;
    logic               win_q, win_d;
    logic               acc_clr, track_en;
    logic [SCORE_W-1:0] acc;
    logic [STATE_W-1:0] max_tracked;
`ifdef SCORE_HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_q, best_d;
    logic               new_best_c;
`endif

    score_accum u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr),
        .dec_en      (dec_en),
        .dec_value   (dec_value),
        .track_en    (track_en),
        .track_state (cell_state),
        .acc         (acc),
        .max_tracked (max_tracked)
    );

    // FSM next-state, address counter and result capture.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        score_d   = score_q;
        max_d     = max_q;
        win_d     = win_q;
        dec_en    = 1'b0;
        dec_state = '0;
        busy      = 1'b1;
        done      = 1'b0;
        acc_clr   = 1'b0;
        track_en  = 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
        best_d     = best_q;
        new_best_c = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_clr = 1'b1;
                    addr_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dec_en    = 1'b1;
                dec_state = cell_state;
                track_en  = 1'b1;
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last cell's decoder result is accumulated this cycle.
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                score_d = acc;
                max_d   = max_tracked;
                win_d   = (max_tracked >= WinCode);
`ifdef SCORE_HIGH_SCORE_EN
                new_best_c = (acc > best_q);
                if (new_best_c) begin
                    best_d = acc;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            score_q <= '0;
            max_q   <= '0;
            win_q   <= 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
            best_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            score_q <= score_d;
            max_q   <= max_d;
            win_q   <= win_d;
`ifdef SCORE_HIGH_SCORE_EN
            best_q  <= best_d;
`endif
        end
    end

    assign cell_addr = addr_q;
    assign score     = score_q;
    assign max_state = max_q;
    assign win       = win_q;
`ifdef SCORE_HIGH_SCORE_EN
    assign best_score = best_q;
    assign new_best   = new_best_c;
`endif

endmodule

// File: tb/tb_score_scan_controller.sv
// Self-checking bench for score_scan_controller: board and decoder models, directed
// and random boards checked against a sum/max reference. Define SCORE_HIGH_SCORE_EN
// to also check best_score / new_best.
module tb_score_scan_controller;
    import score_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  cell_addr;
    logic [STATE_W-1:0] cell_state;
    logic               dec_en;
    logic [STATE_W-1:0] dec_state;
    logic [VAL_W-1:0]   dec_value;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] score;
    logic [STATE_W-1:0] max_state;
    logic               win;
`ifdef SCORE_HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_score;
    logic               new_best;
`endif

    logic [STATE_W-1:0] board [N_CELLS];
    int checks = 0;
    int errors = 0;
    int unsigned best_model = 0;

    score_scan_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cell_addr  (cell_addr),
        .cell_state (cell_state),
        .dec_en     (dec_en),
        .dec_state  (dec_state),
        .dec_value  (dec_value),
        .busy       (busy),
        .done       (done),
        .score      (score),
        .max_state  (max_state),
`ifdef SCORE_HIGH_SCORE_EN
        .win        (win),
        .best_score (best_score),
        .new_best   (new_best)
`else
        .win        (win)
`endif
    );

    always #5 clk = ~clk;

    // Combinational board store.
    assign cell_state = board[cell_addr];

    function automatic int unsigned tile_val(input int unsigned s);
        return (s == 0 || s == 15) ? 0 : (32'd1 << s);
    endfunction

    // Registered decoder model; garbage when not enabled so stray accumulation shows.
    always @(posedge clk) begin
        if (dec_en) dec_value <= VAL_W'(tile_val(32'(dec_state)));
        else        dec_value <= VAL_W'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < int'(N_CELLS); i++) board[i] = '0;
    endtask

    // Runs one scan; mode 0 plain, 1 extra start at +5, 2 reset at +8.
    task automatic run_scan(input string name, input int mode);
        int unsigned exp_score = 0;
        int unsigned exp_max   = 0;
        int c, done_at, dones, dec_cnt, addr_bad;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            exp_score += tile_val(32'(board[i]));
            if (32'(board[i]) > exp_max) exp_max = 32'(board[i]);
        end
        done_at = 0; dones = 0; dec_cnt = 0; addr_bad = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 1;
        repeat (40) begin
            start = (mode == 1 && c == 5);
            if (mode == 2) rst = !(c == 8);
            if (dec_en) begin
                if (32'(cell_addr) != 32'(dec_cnt)) addr_bad++;
                dec_cnt++;
            end
            if (done) begin
                dones++;
                if (done_at == 0) done_at = c;
`ifdef SCORE_HIGH_SCORE_EN
                check({name, " new_best"}, 32'(new_best), 32'(exp_score > best_model));
`endif
            end
            if (mode != 2 && c == 1) check({name, " busy start"}, 32'(busy), 1);
            if (mode != 2 && c == 19) begin
                check({name, " busy after"}, 32'(busy), 0);
                check({name, " addr wrap"}, 32'(cell_addr), 0);
            end
            if (mode == 2 && c == 10) begin
                check({name, " busy rst"}, 32'(busy), 0);
                check({name, " dec_en rst"}, 32'(dec_en), 0);
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (mode == 2) begin
            best_model = 0;
            check({name, " dones"}, 32'(dones), 0);
            check({name, " score"}, 32'(score), 0);
            check({name, " max"}, 32'(max_state), 0);
            check({name, " win"}, 32'(win), 0);
`ifdef SCORE_HIGH_SCORE_EN
            check({name, " best"}, 32'(best_score), 0);
`endif
        end else begin
            check({name, " done_at"}, 32'(done_at), 18);
            check({name, " dones"}, 32'(dones), 1);
            check({name, " dec_cycles"}, 32'(dec_cnt), N_CELLS);
            check({name, " addr_seq"}, 32'(addr_bad), 0);
            check({name, " score"}, 32'(score), exp_score);
            check({name, " max"}, 32'(max_state), exp_max);
            check({name, " win"}, 32'(win), 32'(exp_max >= WIN_STATE));
            if (exp_score > best_model) best_model = exp_score;
`ifdef SCORE_HIGH_SCORE_EN
            check({name, " best"}, 32'(best_score), best_model);
`endif
        end
    endtask

    initial begin
        clear_board();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst dec_en", 32'(dec_en), 0);
        check("rst dec_state", 32'(dec_state), 0);
        check("rst addr", 32'(cell_addr), 0);
        check("rst score", 32'(score), 0);
        check("rst max", 32'(max_state), 0);
        check("rst win", 32'(win), 0);
`ifdef SCORE_HIGH_SCORE_EN
        check("rst best", 32'(best_score), 0);
        check("rst new_best", 32'(new_best), 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        clear_board();
        run_scan("all_zero", 0);

        clear_board();
        board[0] = 4'd1; board[1] = 4'd1;
        run_scan("two_ones", 0);

        clear_board();
        board[5] = 4'd11; board[9] = 4'd3;
        run_scan("win_2048", 0);

        clear_board();
        board[0] = 4'd3;
        run_scan("score_8", 0);

        for (int i = 0; i < int'(N_CELLS); i++) board[i] = 4'd14;
        run_scan("all_14", 0);

        clear_board();
        board[7] = 4'd15;
        run_scan("state_15", 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(N_CELLS); i++) board[i] = STATE_W'($urandom_range(0, 15));
            run_scan($sformatf("random%0d", r), 0);
        end

        clear_board();
        board[2] = 4'd2; board[12] = 4'd6;
        run_scan("mid_start", 1);

        board[3] = 4'd9;
        run_scan("mid_reset", 2);

        rst = 1'b1;
        clear_board();
        board[0] = 4'd1; board[1] = 4'd1;
        run_scan("post_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_scan_controller.md
Name: score_scan_controller

Overview:
- Sequences the tile-value decoder across all board cells to compute the game score after each move.
- On `start`, steps a cell address through the board store and feeds each cell's 4-bit state code to the external registered decoder (1-cycle latency).
- Accumulates the returned tile values and reports score, highest tile state and win flag with a one-cycle `done` pulse.
- Sits between the move engine / board register file and the score display path.

Parameters:
- N_CELLS, 16, number of board cells scanned; address width is $clog2(N_CELLS).
- STATE_W, 4, width of a cell state code (exponent; 0 = empty).
- VAL_W, 16, width of a decoded tile value returned by the decoder.
- SCORE_W, 20, accumulator/score width; must hold N_CELLS * 2^14.
- WIN_STATE, 11, state code at or above which the game is won (11 = tile 2048).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request a scan; sampled only in IDLE
- cell_addr  out  $clog2(N_CELLS)  board read address
- cell_state  in  STATE_W  board data for cell_addr, combinational read, same cycle
- dec_en  out  1  decoder enable
- dec_state  out  STATE_W  state code to decoder
- dec_value  in  VAL_W  decoder result, valid one cycle after dec_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse: score/max_state/win updated
- score  out  SCORE_W  sum of all decoded tile values from last completed scan
- max_state  out  STATE_W  largest cell state code from last completed scan
- win  out  1  max_state >= WIN_STATE from last completed scan

Behaviour:
- Reset (rst == 0 at posedge):
  - FSM goes to IDLE.
  - cell_addr, dec_en, dec_state, busy, done, score, max_state, win, accumulator, max tracker and valid pipe all go to 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - dec_en = 0, busy = 0.
  - start = 1 → clear accumulator and max tracker, cell_addr = 0, go to ISSUE.
- ISSUE (exactly N_CELLS cycles):
  - dec_en = 1; dec_state = cell_state (combinational pass-through); cell_addr increments each cycle.
  - On cell_addr == N_CELLS-1 → go to DRAIN; cell_addr wraps to 0.
  - The max tracker compares cell_state in the same cycle.
- Valid pipe: a 1-bit register equal to the previous cycle's dec_en. When it is set, accumulator += zero-extended dec_value.
  - The decoder returns 0 for state 0 and for state 15; both contribute 0. No error is flagged.
- DRAIN (1 cycle): dec_en = 0; the last cell's value is accumulated.
- DONE (1 cycle):
  - score <= accumulator, max_state <= tracker, win <= (tracker >= WIN_STATE).
  - done = 1; go to IDLE.
- Timing: start accepted at posedge k → ISSUE cycles k+1..k+N_CELLS, DRAIN at k+N_CELLS+1, done high during cycle k+N_CELLS+2.
  - With N_CELLS = 16, done is asserted 18 cycles after start is sampled.
  - busy is high through ISSUE, DRAIN and DONE, and low on the cycle after done.
- start while busy is ignored (not queued). start held high in IDLE immediately after DONE starts a new scan.
- score, max_state and win hold their values between scans; they change only in DONE.
- Accumulator does not saturate; SCORE_W is sized so overflow is impossible for legal codes.
- Reset mid-scan aborts immediately. Outputs return to reset values; no done pulse.

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- Defined:
  - Adds output best_score [SCORE_W] (reset 0).
  - In DONE, best_score <= max(best_score, accumulator).
  - Adds output new_best, a 1-cycle pulse coincident with done when the accumulator is strictly greater than best_score.
- Undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Shared package score_pkg:
  - constants N_CELLS, STATE_W, VAL_W, SCORE_W, WIN_STATE, and the cell address width.
  - FSM state enum typedef scan_state_t {IDLE, ISSUE, DRAIN, DONE}.
- One natural sub-module: score_accum. It holds the valid-pipe register, the SCORE_W adder/accumulator with synchronous clear, and the max-state tracker.
- The FSM and address counter stay in the top module. The decoder remains a separate instance wired by the parent.

Test Plan:
- Board all state 0, start → done at +18 cycles, score = 0, max_state = 0, win = 0; dec_en high for exactly 16 cycles.
- Cells 0 and 1 = state 1, rest 0 → score = 4, max_state = 1, win = 0; cell_addr sequence 0..15 then 0.
- Cell 5 = 11, cell 9 = 3, rest 0 → score = 2056, max_state = 11, win = 1.
- All cells = 14 → score = 262144 (no overflow), max_state = 14; cell state 15 alone → score = 0, max_state = 15, win = 1.
- start pulsed again at +5 cycles during a scan → ignored, single done at +18; rst low at +8 → busy = 0, done never pulses, score stays 0.
- SCORE_HIGH_SCORE_EN: scans scoring 4, then 2056, then 8 → best_score 4, 2056, 2056; new_best pulses on the first two scans only.
